// File: rtl/ysyx_25020047_pkg.sv
// Shared constants for the ysyx_25020047 instruction sequencer: inst_type classes,
// FSM state encoding and fault codes.
package ysyx_25020047_pkg;

   localparam logic [8:0] IT_ADDI   = 9'h001;
   localparam logic [8:0] IT_JALR   = 9'h002;
   localparam logic [8:0] IT_EBREAK = 9'h004;
   localparam logic [8:0] IT_ADD    = 9'h008;
   localparam logic [8:0] IT_LUI    = 9'h010;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_STOP   = 3'd5;

   typedef enum logic [1:0] {
      FC_NONE    = 2'b00,
      FC_ILLEGAL = 2'b01,
      FC_TIMEOUT = 2'b10
   } fault_code_e;

   // A class vector is legal only with exactly one bit set.
   function automatic logic is_onehot(input logic [8:0] v);
      return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
   endfunction

endpackage

// File: rtl/ysyx_25020047_perf_cnt.sv
// Free-running cycle and retired-instruction counters for the sequencer;
// only built when YSYX_25020047_PERF_EN is defined.
module ysyx_25020047_perf_cnt (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cyc_en_i,
   input  logic        ret_i,
   output logic [63:0] cycle_cnt_o,
   output logic [63:0] instret_o
);

   logic [63:0] cycle_q, cycle_d;
   logic [63:0] instret_q, instret_d;

   // Next-count selection
   always_comb begin
      cycle_d   = cycle_q;
      instret_d = instret_q;
      if (cyc_en_i) begin
         cycle_d = cycle_q + 64'd1;
      end else begin
         cycle_d = cycle_q;
      end
      if (ret_i) begin
         instret_d = instret_q + 64'd1;
      end else begin
         instret_d = instret_q;
      end
   end

   // Counter registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycle_q   <= 64'd0;
         instret_q <= 64'd0;
      end else begin
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
      end
   end

   assign cycle_cnt_o = cycle_q;
   assign instret_o   = instret_q;

endmodule

// File: rtl/ysyx_25020047_seq.sv
// Multi-cycle sequencer: IDLE -> FETCH -> DECODE -> EXEC -> WB, with STOP on halt/fault.
// Optional perf counters under YSYX_25020047_PERF_EN.
module ysyx_25020047_seq
   import ysyx_25020047_pkg::*;
#(
   parameter logic [7:0] FETCH_TIMEOUT = 8'd255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic        ifu_req_o,
   input  logic        ifu_valid_i,
   input  logic [31:0] ifu_rdata_i,
   output logic [31:0] inst_o,
   input  logic [8:0]  inst_type_i,
   output logic        reg_wen_o,
   output logic        pc_wen_o,
   output logic        halt_o,
   output logic        fault_o,
`ifdef YSYX_25020047_PERF_EN
   output logic [63:0] cycle_cnt_o,
   output logic [63:0] instret_o,
`endif
   output logic [1:0]  fault_code_o
);

   logic [2:0]  state_q, state_d;
   logic [31:0] inst_q, inst_d;
   logic [8:0]  type_q, type_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        halt_q, halt_d;
   logic        fault_q, fault_d;
   fault_code_e code_q, code_d;

   // Next-state and sticky-status logic
   always_comb begin
      state_d = state_q;
      inst_d  = inst_q;
      type_d  = type_q;
      cnt_d   = cnt_q;
      halt_d  = halt_q;
      fault_d = fault_q;
      code_d  = code_q;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            // A word arriving on the final allowed cycle still wins over the timeout.
            if (ifu_valid_i) begin
               inst_d  = ifu_rdata_i;
               cnt_d   = 8'd0;
               state_d = ST_DECODE;
            end else if (cnt_q == (FETCH_TIMEOUT - 8'd1)) begin
               cnt_d   = FETCH_TIMEOUT;
               fault_d = 1'b1;
               code_d  = FC_TIMEOUT;
               state_d = ST_STOP;
            end else begin
               cnt_d   = cnt_q + 8'd1;
            end
         end
         ST_DECODE: begin
            type_d  = inst_type_i;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (!is_onehot(type_q)) begin
               fault_d = 1'b1;
               code_d  = FC_ILLEGAL;
               state_d = ST_STOP;
            end else if (type_q == IT_EBREAK) begin
               halt_d  = 1'b1;
               state_d = ST_STOP;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_WB:   state_d = ST_FETCH;
         ST_STOP: state_d = ST_STOP;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         inst_q  <= 32'd0;
         type_q  <= 9'd0;
         cnt_q   <= 8'd0;
         halt_q  <= 1'b0;
         fault_q <= 1'b0;
         code_q  <= FC_NONE;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         type_q  <= type_d;
         cnt_q   <= cnt_d;
         halt_q  <= halt_d;
         fault_q <= fault_d;
         code_q  <= code_d;
      end
   end

   // Strobes decode from the state register alone so reset drops them immediately.
   assign ifu_req_o    = (state_q == ST_FETCH);
   assign reg_wen_o    = (state_q == ST_WB);
   assign pc_wen_o     = (state_q == ST_WB);
   assign inst_o       = inst_q;
   assign halt_o       = halt_q;
   assign fault_o      = fault_q;
   assign fault_code_o = code_q;

`ifdef YSYX_25020047_PERF_EN
   logic perf_cyc_en_s;
   logic perf_ret_s;

   assign perf_cyc_en_s = (state_q != ST_STOP);
   assign perf_ret_s    = (state_q == ST_WB) ||
                          ((state_q == ST_EXEC) && (type_q == IT_EBREAK));

   ysyx_25020047_perf_cnt u_perf_cnt (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .cyc_en_i    (perf_cyc_en_s),
      .ret_i       (perf_ret_s),
      .cycle_cnt_o (cycle_cnt_o),
      .instret_o   (instret_o)
   );
`endif

endmodule

// File: doc/ysyx_25020047_seq.md
# ysyx_25020047_seq

Multi-cycle instruction sequencer for the single-issue core: holds the fetched instruction, drives the fetch handshake, and issues single-cycle write enables for the register file and PC. The decode unit's inst_type result steers the writeback and halt decisions. Sits between instruction memory, the decode/regfile unit and the PC register; one instruction completes every 4 cycles plus fetch wait.

## Interface
- FETCH_TIMEOUT, 255: cycles allowed in FETCH without ifu_valid before faulting; 8-bit counter, legal 1..255
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- ifu_req  out  1  fetch request for the current pc
- ifu_valid  in  1  instruction word valid; accepted only while ifu_req=1
- ifu_rdata  in  32  fetched instruction word
- inst  out  32  latched instruction to decode
- inst_type  in  9  one-hot class from decode: bit0 addi, bit1 jalr, bit2 ebreak, bit3 add, bit4 lui, 0 = illegal
- reg_wen  out  1  register-file write strobe
- pc_wen  out  1  PC commit strobe (dnpc → pc)
- halt  out  1  sticky: ebreak retired
- fault  out  1  sticky: illegal instruction or fetch timeout
- fault_code  out  2  00 none, 01 illegal, 10 fetch timeout

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, STOP.
- IDLE: entered from reset; advances to FETCH the next cycle.
- FETCH: ifu_req=1. When ifu_valid=1, latch ifu_rdata into inst, clear timeout counter, go to DECODE. Each cycle without ifu_valid increments the counter; when counter reaches FETCH_TIMEOUT with ifu_valid still 0, set fault=1, fault_code=10, go to STOP.
- DECODE: inst stable; decode settles. Sample inst_type into an internal register; go to EXEC.
- EXEC: sampled inst_type == 0 or not one-hot → fault=1, fault_code=01, STOP. ebreak → halt=1, STOP, no writes. Otherwise go to WB.
- WB: reg_wen=1 and pc_wen=1 for exactly this cycle (all four legal non-ebreak classes write rd; rd=x0 discarded by the register file). Return to FETCH.
- STOP: terminal; all strobes 0; halt/fault/fault_code held until reset.
- inst is modified only on FETCH acceptance; holds its value in all other states.

## Timing
- Reset values: state IDLE, ifu_req 0, inst 0, reg_wen 0, pc_wen 0, halt 0, fault 0, fault_code 00, timeout counter 0.
- All outputs registered or decoded from the state register only; no combinational path from ifu_valid or inst_type to any output.
- Fetch accepted with zero wait: ifu_req rises cycle N, ifu_valid at N → DECODE at N+1, EXEC N+2, WB N+3, next FETCH N+4.
- ifu_valid while ifu_req=0 is ignored.
- Timeout with FETCH_TIMEOUT=T: ifu_valid never arrives → fault asserts exactly T cycles after entering FETCH. ifu_valid on the same cycle the counter reaches T wins: accepted, no fault.
- Reset asserted in any state (including mid-FETCH or WB) forces reset values asynchronously; a strobe in flight is dropped. Deassertion restarts from IDLE.
- reg_wen and pc_wen are never high in consecutive cycles.

## Configuration
- YSYX_25020047_PERF_EN defined: adds outputs cycle_cnt (64, counts every cycle out of reset, freezes in STOP) and instret (64, +1 on each WB cycle and on the EXEC→STOP ebreak transition); both reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package ysyx_25020047_pkg: inst_type one-hot constants (ADDI, JALR, EBREAK, ADD, LUI), state encoding, fault_code constants.
- One sub-module, ysyx_25020047_perf_cnt, holding both 64-bit counters; instantiated only under YSYX_25020047_PERF_EN.

## Test plan
- Reset then ifu_valid held 1, rdata=addi x1,x0,5 (0x00500093), inst_type=0x001 → ifu_req at cycle 1, reg_wen=pc_wen=1 at cycle 4, ifu_req again cycle 5.
- Fetch wait of 3 cycles on add (0x002081B3, inst_type=0x008) → inst unchanged until acceptance; WB exactly 3 cycles later than zero-wait case.
- ebreak (0x00100073, inst_type=0x004) → halt=1 after EXEC, no reg_wen/pc_wen, ifu_req stays 0 for 20 cycles.
- inst_type=0x000 → fault=1, fault_code=01, no strobes; inst_type=0x003 (not one-hot) → same.
- FETCH_TIMEOUT=4, ifu_valid never → fault_code=10 exactly 4 cycles after FETCH entry; repeat with ifu_valid on the 4th cycle → accepted, no fault.
- rst low during WB → reg_wen/pc_wen drop same cycle asynchronously, all outputs reset; with PERF_EN, cycle_cnt and instret read 0 after release.
